// File: rtl/timer_link_pkg.sv
// Shared definitions for the serial timer-command link.
// The transmitter and the receiver both import this package, so the start pattern is defined in one place.
package timer_link_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StWaitDone,
        StAck,
        StGap
    } link_state_e;

    localparam logic [3:0] LINK_PREAMBLE = 4'b1101;
    localparam int unsigned DEFAULT_DELAY_W = 4;

endpackage

// File: rtl/tx_piso_shift.sv
// Parallel-load shift register with a registered MSB-first serial output.
// The first bit appears in the cycle right after the load.
module tx_piso_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] sreg;

    // sreg holds the bits that are still to be sent, left-aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            sout <= 1'b0;
        end else if (load) begin
            sout <= din[WIDTH-1];
            sreg <= {din[WIDTH-2:0], 1'b0};
        end else if (shift) begin
            sout <= sreg[WIDTH-1];
            sreg <= {sreg[WIDTH-2:0], 1'b0};
        end else if (clear) begin
            sout <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_cmd_serializer.sv
// Transmit end of the serial timer-command link.
// Sends the preamble and then the delay value, waits for done, and answers with a one-cycle ack.
module timer_cmd_serializer
    import timer_link_pkg::*;
#(
    parameter int unsigned DELAY_W        = DEFAULT_DELAY_W,
    parameter logic [3:0]  PREAMBLE       = LINK_PREAMBLE,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [DELAY_W-1:0] cmd_delay,
    output logic               cmd_ready,
    output logic               data,
    input  logic               done,
    output logic               ack,
    output logic               busy,
    output logic               timeout_err
);

    localparam int unsigned FRAME_W = 4 + DELAY_W;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int unsigned TO_MAX  = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
    localparam int unsigned TO_W    = $clog2(TO_MAX + 1);

    link_state_e       state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TO_W-1:0]   wait_cnt;

    logic accept;
    logic last_bit;
    logic sh_shift;
    logic sh_clear;

    assign accept   = cmd_valid && cmd_ready;
    assign last_bit = (bit_cnt == BIT_W'(FRAME_W - 1));
    assign sh_shift = (state == StShift) && !last_bit;
    assign sh_clear = (state == StShift) && last_bit;

    tx_piso_shift #(
        .WIDTH (FRAME_W)
    ) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (sh_shift),
        .clear (sh_clear),
        .din   ({PREAMBLE, cmd_delay}),
        .sout  (data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            ack         <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ack         <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        state     <= StShift;
                        bit_cnt   <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                StShift: begin
                    if (last_bit) begin
                        state    <= StWaitDone;
                        wait_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                StWaitDone: begin
                    // done takes priority over a timeout that expires on the same edge.
                    if (done) begin
                        state <= StAck;
                        ack   <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0 && wait_cnt == TO_W'(TO_MAX - 1)) begin
                        state       <= StGap;
                        gap_cnt     <= '0;
                        timeout_err <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StAck: begin
                    state   <= StGap;
                    gap_cnt <= '0;
                end
                StGap: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state     <= StIdle;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_cmd_serializer.sv
// Directed bench for timer_cmd_serializer. A second instance with a short timeout
// is used only for the abort scenario.
module tb_timer_cmd_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [3:0] cmd_delay;
    logic       done;
    logic       done_to;
    logic       cmd_ready, data, ack, busy, timeout_err;
    logic       to_ready, to_data, to_ack, to_busy, to_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    timer_cmd_serializer #(
        .DELAY_W        (4),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (20000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_delay   (cmd_delay),
        .cmd_ready   (cmd_ready),
        .data        (data),
        .done        (done),
        .ack         (ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    timer_cmd_serializer #(
        .DELAY_W        (4),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (10)
    ) dut_to (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_delay   (cmd_delay),
        .cmd_ready   (to_ready),
        .data        (to_data),
        .done        (done_to),
        .ack         (to_ack),
        .busy        (to_busy),
        .timeout_err (to_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Entered in cycle k+1; leaves in cycle k+9.
    task automatic check_frame(input logic [7:0] f, input string tag);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_data"}, data, f[7-i]);
            check({tag, "_ready"}, cmd_ready, 1'b0);
            check({tag, "_busy"}, busy, 1'b1);
            tick();
        end
    endtask

    logic exp_data  [0:23] = '{0, 1,1,0,1,0,0,1,1, 0,0,0,0,0, 1,1,0,1,1,1,1,1, 0,0};
    logic [7:0] f;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_delay = 4'h0;
        done      = 1'b0;
        done_to   = 1'b0;

        // Reset values, a basic frame, then done and ack timing.
        do_reset();
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_data", data, 1'b0);
        check("rst_ack", ack, 1'b0);
        check("rst_err", timeout_err, 1'b0);

        cmd_valid = 1'b1;
        cmd_delay = 4'b1010;
        tick();
        cmd_valid = 1'b0;
        cmd_delay = 4'h0;
        check_frame(8'b1101_1010, "f1");
        for (int c = 9; c < 20; c++) begin
            check("wait_data", data, 1'b0);
            check("wait_ack", ack, 1'b0);
            check("wait_busy", busy, 1'b1);
            tick();
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        check("ack_hi", ack, 1'b1);
        check("ack_data", data, 1'b0);
        tick();
        check("gap1_ack", ack, 1'b0);
        check("gap1_data", data, 1'b0);
        check("gap1_ready", cmd_ready, 1'b0);
        tick();
        check("gap2_data", data, 1'b0);
        check("gap2_ready", cmd_ready, 1'b0);
        check("gap2_busy", busy, 1'b1);
        tick();
        check("idle_ready", cmd_ready, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("idle_data", data, 1'b0);

        // Back-to-back frames at the minimum interval with cmd_valid and done held high.
        do_reset();
        cmd_valid = 1'b1;
        cmd_delay = 4'h3;
        done      = 1'b1;
        for (int c = 0; c < 24; c++) begin
            check("b2b_data", data, exp_data[c]);
            check("b2b_ack", ack, (c == 10 || c == 23));
            check("b2b_ready", cmd_ready, (c == 0 || c == 13));
            if (c == 1) cmd_delay = 4'hF;
            if (c == 14) cmd_valid = 1'b0;
            tick();
        end
        done = 1'b0;

        // Timeout abort on the short-timeout instance.
        do_reset();
        cmd_valid = 1'b1;
        cmd_delay = 4'h5;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c < 23; c++) begin
            check("to_err", to_err, (c == 19));
            check("to_ack", to_ack, 1'b0);
            check("to_ready", to_ready, (c >= 21));
            check("to_busy", to_busy, (c < 21));
            tick();
        end

        // done during SHIFT is ignored.
        do_reset();
        f = 8'b1101_0110;
        cmd_valid = 1'b1;
        cmd_delay = 4'b0110;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int c = 4; c < 9; c++) begin
            check("sd_data", data, f[8-c]);
            tick();
        end
        for (int c = 9; c < 13; c++) begin
            check("sd_ack", ack, 1'b0);
            check("sd_busy", busy, 1'b1);
            check("sd_data0", data, 1'b0);
            tick();
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        check("sd_ack_late", ack, 1'b1);

        // Reset mid-payload, then a fresh command.
        do_reset();
        f = 8'b1101_1100;
        cmd_valid = 1'b1;
        cmd_delay = 4'b1100;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c < 6; c++) begin
            check("mr_data", data, f[8-c]);
            tick();
        end
        check("mr_data6", data, f[2]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_data0", data, 1'b0);
        check("mr_ack", ack, 1'b0);
        check("mr_ready", cmd_ready, 1'b1);
        check("mr_busy", busy, 1'b0);
        check("mr_err", timeout_err, 1'b0);
        cmd_valid = 1'b1;
        cmd_delay = 4'b1001;
        tick();
        cmd_valid = 1'b0;
        check_frame(8'b1101_1001, "f6");
        check("f6_tail", data, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
